rob_tid_alloc: RTL and testbench
================================

// Module: rob_tid_alloc
// PURPOSE
//  Request-side counterpart of the ROB. Accepts AXI read requests, stamps each with a
//  sequential transaction ID (tID) and forwards it to tag compare. Stores each request's
//  AXI ID in a tID-indexed table. When the ROB retires a tID, the block returns the
//  stored AXI ID for use as rid. tIDs start at 1 to match the ROB's reset tID.
// PARAMETERS
//  ADDR_WIDTH  `AXI_ADDR_WIDTH  request address width
//  ID_WIDTH    `AXI_ID_WIDTH    AXI ID width
//  TID_WIDTH   `TID_WIDTH       tID width; DEPTH = 2**TID_WIDTH table entries
// PORTS
//  clk            in   1           single clock
//  rst            in   1           synchronous, active-high reset
//  arvalid_i      in   1           AXI read request valid
//  arready_o      out  1           AXI read request ready
//  arid_i         in   ID_WIDTH    AXI read ID
//  araddr_i       in   ADDR_WIDTH  AXI read address
//  req_valid_o    out  1           tagged request to tag compare, valid
//  req_ready_i    in   1           tag compare ready
//  req_tid_o      out  TID_WIDTH   assigned tID
//  req_addr_o     out  ADDR_WIDTH  forwarded address
//  ret_valid_i    in   1           ROB retire strobe (one per cycle max, tID order)
//  ret_tid_i      in   TID_WIDTH   retired tID
//  ret_id_valid_o out  1           ret_id_o valid (1 cycle after ret_valid_i)
//  ret_id_o       out  ID_WIDTH    AXI ID stored for the retired tID
//  outstanding_o  out  TID_WIDTH+1 allocated-but-not-retired count
// BEHAVIOUR
//  - Reset: arready_o=0 during rst; req_valid_o=0; req_tid_o=0; req_addr_o=0;
//    ret_id_valid_o=0; ret_id_o=0; outstanding_o=0; next_tid=1; state=S_IDLE.
//  - Output stage FSM:
//    S_IDLE: on accept, go to S_VAL.
//    S_VAL: req_valid_o=1 and outputs held stable. On req_ready_i & accept, stay in
//    S_VAL with the new request. On req_ready_i & !accept, go to S_IDLE.
//  - arready_o = !rst & (outstanding_o < DEPTH) & (state==S_IDLE | req_ready_i).
//  - accept = arvalid_i & arready_o. On accept:
//    - table[next_tid] <= arid_i
//    - req_tid_o <= next_tid; req_addr_o <= araddr_i
//    - next_tid <= next_tid+1, modulo 2**TID_WIDTH (wraps DEPTH-1 -> 0; 0 is a legal tID)
//  - Latency: accept to req_valid_o = 1 cycle. Full throughput with req_ready_i held at 1.
//  - Retire: on ret_valid_i with outstanding_o > 0:
//    - next cycle: ret_id_o = table[ret_tid_i], ret_id_valid_o = 1
//    - ret_id_valid_o is a 1-cycle pulse per retire
//  - outstanding_o: +1 on accept, -1 on valid retire; accept and retire in the same cycle
//    leave it unchanged.
//  - Full (outstanding_o == DEPTH): arready_o=0. A retire in the same cycle does not raise
//    arready_o until the next cycle (no comb path from ret_valid_i to arready_o).
//  - Retire with outstanding_o == 0: ignored; count unchanged; ret_id_valid_o stays 0.
//  - Same-cycle write and read of one table entry cannot occur (a tID in flight is never
//    reallocated while outstanding).
//  - Reset mid-operation: all in-flight state dropped. Table contents are don't-care.
// CONFIGURATION
//  ROB_ORDER_CHECK_EN defined:
//    - adds a retire_tid pointer (reset 1) and an output err_o (1 bit, reset 0)
//    - err_o sets sticky when ret_tid_i != retire_tid or a retire occurs with count 0
//    - retire_tid increments on each valid retire; err_o clears only on rst
//  ROB_ORDER_CHECK_EN undefined: no err_o port, no checker logic. Behaviour is otherwise
//    identical.
// TESTING
//  1. Reset, then 3 requests (arid 5,6,7, req_ready_i=1):
//     -> req_tid_o 1,2,3 on consecutive cycles; outstanding_o=3.
//  2. Retire tids 1,2,3:
//     -> ret_id_o 5,6,7, each 1 cycle later; outstanding_o returns to 0.
//  3. Fill DEPTH requests with no retires:
//     -> arready_o=0. One retire -> arready_o=1 the next cycle; new tID = previous+1
//        modulo DEPTH.
//  4. req_ready_i=0 for 4 cycles while the stage holds tid 1:
//     -> req_tid_o/req_addr_o stable; arready_o=0; no tID skipped.
//  5. Accept and retire in the same cycle with count=2:
//     -> count stays 2; ret_id_o correct; new tID entry written correctly.
//  6. With ROB_ORDER_CHECK_EN: retire tid 2 when 1 is expected -> err_o=1 and stays 1.
//     Assert rst -> err_o=0 and next_tid=1.

Source files
------------

// File: rtl/rob_tid_alloc_if.sv
// Request, tagged-request and retire signals of the ROB tID allocator.
interface rob_tid_alloc_if #(
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned ID_WIDTH   = 4,
  parameter int unsigned TID_WIDTH  = 4
);
  logic                  arvalid_i;
  logic                  arready_o;
  logic [ID_WIDTH-1:0]   arid_i;
  logic [ADDR_WIDTH-1:0] araddr_i;
  logic                  req_valid_o;
  logic                  req_ready_i;
  logic [TID_WIDTH-1:0]  req_tid_o;
  logic [ADDR_WIDTH-1:0] req_addr_o;
  logic                  ret_valid_i;
  logic [TID_WIDTH-1:0]  ret_tid_i;
  logic                  ret_id_valid_o;
  logic [ID_WIDTH-1:0]   ret_id_o;
  logic [TID_WIDTH:0]    outstanding_o;

  modport slave (
    input  arvalid_i, arid_i, araddr_i, req_ready_i, ret_valid_i, ret_tid_i,
    output arready_o, req_valid_o, req_tid_o, req_addr_o, ret_id_valid_o, ret_id_o,
           outstanding_o
  );

  modport master (
    output arvalid_i, arid_i, araddr_i, req_ready_i, ret_valid_i, ret_tid_i,
    input  arready_o, req_valid_o, req_tid_o, req_addr_o, ret_id_valid_o, ret_id_o,
           outstanding_o
  );
endinterface

// File: rtl/rob_tid_alloc.sv
// Stamps AXI read requests with sequential tIDs and returns the stored AXI ID on retire.
// Optional retire-order checker (err_o) enabled by defining ROB_ORDER_CHECK_EN.
module rob_tid_alloc #(
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned ID_WIDTH   = 4,
  parameter int unsigned TID_WIDTH  = 4
) (
  input  logic           clk,
  input  logic           rst,
`ifdef ROB_ORDER_CHECK_EN
  output logic           err_o,
`endif
  rob_tid_alloc_if.slave bus
);

  localparam int unsigned DEPTH = 2 ** TID_WIDTH;
  localparam int unsigned CNT_W = TID_WIDTH + 1;

  typedef enum logic {S_IDLE, S_VAL} state_t;

  state_t                state;
  logic                  req_valid;
  logic [TID_WIDTH-1:0]  req_tid;
  logic [ADDR_WIDTH-1:0] req_addr;
  logic [TID_WIDTH-1:0]  next_tid;
  logic [CNT_W-1:0]      outstanding;
  logic                  ret_id_valid;
  logic [ID_WIDTH-1:0]   ret_id;
  logic [ID_WIDTH-1:0]   id_table [DEPTH];

  logic arready;
  logic accept;
  logic ret_ok;

  // Fullness uses only the registered count, so a retire frees a slot one cycle later.
  assign arready = !rst && (outstanding < CNT_W'(DEPTH)) &&
                   ((state == S_IDLE) || bus.req_ready_i);
  assign accept  = bus.arvalid_i && arready;
  assign ret_ok  = bus.ret_valid_i && (outstanding != '0);

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= S_IDLE;
      req_valid    <= 1'b0;
      req_tid      <= '0;
      req_addr     <= '0;
      next_tid     <= TID_WIDTH'(1);
      outstanding  <= '0;
      ret_id_valid <= 1'b0;
      ret_id       <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (accept) begin
            state     <= S_VAL;
            req_valid <= 1'b1;
          end
        end
        S_VAL: begin
          if (bus.req_ready_i && !accept) begin
            state     <= S_IDLE;
            req_valid <= 1'b0;
          end
        end
        default: begin
          state     <= S_IDLE;
          req_valid <= 1'b0;
        end
      endcase

      if (accept) begin
        req_tid  <= next_tid;
        req_addr <= bus.araddr_i;
        next_tid <= next_tid + TID_WIDTH'(1);
      end

      case ({accept, ret_ok})
        2'b10:   outstanding <= outstanding + CNT_W'(1);
        2'b01:   outstanding <= outstanding - CNT_W'(1);
        default: outstanding <= outstanding;
      endcase

      ret_id_valid <= ret_ok;
      if (ret_ok) begin
        ret_id <= id_table[bus.ret_tid_i];
      end
    end
  end

  // Table contents are don't-care after reset; no reset on the storage.
  always_ff @(posedge clk) begin
    if (accept) begin
      id_table[next_tid] <= bus.arid_i;
    end
  end

`ifdef ROB_ORDER_CHECK_EN
  logic [TID_WIDTH-1:0] retire_tid;

  // Sticky flag for out-of-order retires or retires with nothing outstanding.
  always_ff @(posedge clk) begin
    if (rst) begin
      retire_tid <= TID_WIDTH'(1);
      err_o      <= 1'b0;
    end else begin
      if (bus.ret_valid_i && ((bus.ret_tid_i != retire_tid) || (outstanding == '0))) begin
        err_o <= 1'b1;
      end
      if (ret_ok) begin
        retire_tid <= retire_tid + TID_WIDTH'(1);
      end
    end
  end
`endif

  assign bus.arready_o      = arready;
  assign bus.req_valid_o    = req_valid;
  assign bus.req_tid_o      = req_tid;
  assign bus.req_addr_o     = req_addr;
  assign bus.ret_id_valid_o = ret_id_valid;
  assign bus.ret_id_o       = ret_id;
  assign bus.outstanding_o  = outstanding;

endmodule

// File: tb/tb_rob_tid_alloc.sv
// Directed bench for rob_tid_alloc with DEPTH = 8 (TID_WIDTH = 3).
module tb_rob_tid_alloc;

  localparam int unsigned AW = 16;
  localparam int unsigned IW = 4;
  localparam int unsigned TW = 3;

  logic clk;
  logic rst;
`ifdef ROB_ORDER_CHECK_EN
  logic err;
`endif

  int checks;
  int errors;

  logic [IW-1:0] exp_tab [8];

  rob_tid_alloc_if #(.ADDR_WIDTH(AW), .ID_WIDTH(IW), .TID_WIDTH(TW)) bus ();

  rob_tid_alloc #(.ADDR_WIDTH(AW), .ID_WIDTH(IW), .TID_WIDTH(TW)) dut (
    .clk   (clk),
    .rst   (rst),
`ifdef ROB_ORDER_CHECK_EN
    .err_o (err),
`endif
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Present one request, confirm it is accepted and appears on the output stage.
  task automatic accept_req(input logic [IW-1:0] id, input logic [AW-1:0] addr,
                            input logic [TW-1:0] tid);
    bus.arvalid_i = 1'b1;
    bus.arid_i    = id;
    bus.araddr_i  = addr;
    #1;
    chk("arready_accept", 32'(bus.arready_o), 32'd1);
    tick();
    exp_tab[tid] = id;
    chk("req_valid", 32'(bus.req_valid_o), 32'd1);
    chk("req_tid", 32'(bus.req_tid_o), 32'(tid));
    chk("req_addr", 32'(bus.req_addr_o), 32'(addr));
  endtask

  task automatic retire(input logic [TW-1:0] tid, input int exp_out);
    bus.ret_valid_i = 1'b1;
    bus.ret_tid_i   = tid;
    tick();
    chk("ret_id_valid", 32'(bus.ret_id_valid_o), 32'd1);
    chk("ret_id", 32'(bus.ret_id_o), 32'(exp_tab[tid]));
    chk("outstanding_ret", 32'(bus.outstanding_o), 32'(exp_out));
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end

  initial begin
    logic [TW-1:0] t;
    checks = 0;
    errors = 0;
    for (int i = 0; i < 8; i++) exp_tab[i] = '0;
    rst             = 1'b1;
    bus.arvalid_i   = 1'b0;
    bus.arid_i      = '0;
    bus.araddr_i    = '0;
    bus.req_ready_i = 1'b1;
    bus.ret_valid_i = 1'b0;
    bus.ret_tid_i   = '0;

    // Reset state
    tick();
    tick();
    bus.arvalid_i = 1'b1;
    #1;
    chk("arready_in_rst", 32'(bus.arready_o), 32'd0);
    bus.arvalid_i = 1'b0;
    chk("rst_req_valid", 32'(bus.req_valid_o), 32'd0);
    chk("rst_req_tid", 32'(bus.req_tid_o), 32'd0);
    chk("rst_req_addr", 32'(bus.req_addr_o), 32'd0);
    chk("rst_outstanding", 32'(bus.outstanding_o), 32'd0);
    chk("rst_ret_id_valid", 32'(bus.ret_id_valid_o), 32'd0);
    chk("rst_ret_id", 32'(bus.ret_id_o), 32'd0);
`ifdef ROB_ORDER_CHECK_EN
    chk("rst_err", 32'(err), 32'd0);
`endif
    rst = 1'b0;
    #1;
    chk("arready_after_rst", 32'(bus.arready_o), 32'd1);

    // Three back-to-back requests get tIDs 1,2,3
    for (int i = 0; i < 3; i++) accept_req(IW'(5 + i), AW'(32'h100 + 4 * i), TW'(1 + i));
    bus.arvalid_i = 1'b0;
    tick();
    chk("t1_req_valid_drop", 32'(bus.req_valid_o), 32'd0);
    chk("t1_outstanding", 32'(bus.outstanding_o), 32'd3);

    // Retire 1,2,3 returns arids 5,6,7
    retire(TW'(1), 2);
    retire(TW'(2), 1);
    retire(TW'(3), 0);
    bus.ret_valid_i = 1'b0;
    tick();
    chk("t2_ret_pulse_end", 32'(bus.ret_id_valid_o), 32'd0);

    // Retire with nothing outstanding is ignored
    bus.ret_valid_i = 1'b1;
    bus.ret_tid_i   = TW'(4);
    tick();
    bus.ret_valid_i = 1'b0;
    chk("empty_ret_valid", 32'(bus.ret_id_valid_o), 32'd0);
    chk("empty_ret_count", 32'(bus.outstanding_o), 32'd0);
`ifdef ROB_ORDER_CHECK_EN
    chk("empty_ret_err", 32'(err), 32'd1);
`endif

    // Fill all 8 entries; tIDs wrap 7 -> 0
    t = TW'(4);
    for (int i = 0; i < 8; i++) begin
      accept_req(IW'(9 + i), AW'(32'h200 + 4 * i), t);
      t = t + TW'(1);
    end
    bus.arid_i   = IW'(2);
    bus.araddr_i = AW'(16'h300);
    #1;
    chk("full_arready", 32'(bus.arready_o), 32'd0);
    tick();
    chk("full_req_valid", 32'(bus.req_valid_o), 32'd0);
    chk("full_outstanding", 32'(bus.outstanding_o), 32'd8);
    bus.ret_valid_i = 1'b1;
    bus.ret_tid_i   = TW'(4);
    #1;
    chk("full_ret_same_cycle_arready", 32'(bus.arready_o), 32'd0);
    tick();
    bus.ret_valid_i = 1'b0;
    chk("full_ret_id", 32'(bus.ret_id_o), 32'd9);
    chk("full_ret_count", 32'(bus.outstanding_o), 32'd7);
    accept_req(IW'(2), AW'(16'h300), TW'(4));
    chk("refill_outstanding", 32'(bus.outstanding_o), 32'd8);
    bus.arvalid_i = 1'b0;
    t = TW'(5);
    for (int i = 0; i < 8; i++) begin
      retire(t, 7 - i);
      t = t + TW'(1);
    end
    bus.ret_valid_i = 1'b0;
    tick();

    // Reset with a request in flight drops everything
    accept_req(IW'(1), AW'(16'h3F0), TW'(5));
    bus.arvalid_i = 1'b0;
    rst = 1'b1;
    tick();
    chk("midrst_outstanding", 32'(bus.outstanding_o), 32'd0);
    chk("midrst_req_valid", 32'(bus.req_valid_o), 32'd0);
    chk("midrst_req_tid", 32'(bus.req_tid_o), 32'd0);
    rst = 1'b0;

    // Back-pressure holds tid 1 stable and blocks new requests
    bus.req_ready_i = 1'b0;
    accept_req(IW'(3), AW'(16'h3A0), TW'(1));
    bus.arid_i   = IW'(4);
    bus.araddr_i = AW'(16'h3B0);
    for (int i = 0; i < 4; i++) begin
      #1;
      chk("bp_arready", 32'(bus.arready_o), 32'd0);
      tick();
      chk("bp_req_valid", 32'(bus.req_valid_o), 32'd1);
      chk("bp_req_tid", 32'(bus.req_tid_o), 32'd1);
      chk("bp_req_addr", 32'(bus.req_addr_o), 32'h3A0);
      chk("bp_outstanding", 32'(bus.outstanding_o), 32'd1);
    end
    bus.req_ready_i = 1'b1;
    accept_req(IW'(4), AW'(16'h3B0), TW'(2));
    bus.arvalid_i = 1'b0;
    tick();
    chk("bp_outstanding_end", 32'(bus.outstanding_o), 32'd2);

    // Accept and retire in the same cycle with count 2
    bus.arvalid_i   = 1'b1;
    bus.arid_i      = IW'(9);
    bus.araddr_i    = AW'(16'h3C0);
    bus.ret_valid_i = 1'b1;
    bus.ret_tid_i   = TW'(1);
    #1;
    chk("both_arready", 32'(bus.arready_o), 32'd1);
    tick();
    exp_tab[3] = IW'(9);
    bus.arvalid_i = 1'b0;
    chk("both_outstanding", 32'(bus.outstanding_o), 32'd2);
    chk("both_ret_id", 32'(bus.ret_id_o), 32'd3);
    chk("both_ret_id_valid", 32'(bus.ret_id_valid_o), 32'd1);
    chk("both_req_tid", 32'(bus.req_tid_o), 32'd3);
    retire(TW'(2), 1);
    retire(TW'(3), 0);
    bus.ret_valid_i = 1'b0;
    tick();

`ifdef ROB_ORDER_CHECK_EN
    // Out-of-order retire sets a sticky error cleared only by reset
    rst = 1'b1;
    tick();
    chk("chk_rst_err", 32'(err), 32'd0);
    rst = 1'b0;
    accept_req(IW'(1), AW'(16'h10), TW'(1));
    accept_req(IW'(2), AW'(16'h14), TW'(2));
    bus.arvalid_i   = 1'b0;
    bus.ret_valid_i = 1'b1;
    bus.ret_tid_i   = TW'(2);
    tick();
    bus.ret_valid_i = 1'b0;
    chk("order_err_set", 32'(err), 32'd1);
    tick();
    chk("order_err_sticky", 32'(err), 32'd1);
    rst = 1'b1;
    tick();
    chk("order_err_clear", 32'(err), 32'd0);
    rst = 1'b0;
    accept_req(IW'(7), AW'(16'h20), TW'(1));
    bus.arvalid_i = 1'b0;
    tick();
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
